// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- Coprocessor-0 register file
//
// Holds Status, Cause, EPC, BadVAddr and, optionally, the Count/Compare timer.
// Exception updates come from the MEM stage. The registered EPC feeds eret
// redirection. mfc0 reads are combinational. mtc0 writes arrive from WB.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : Count/Compare timer and sticky timer_int_o are implemented.
//   undefined : Count/Compare read as 0 and writes to them are dropped.
//               count_o, compare_o and timer_int_o are tied to 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   we_i/waddr_i/data_i  mtc0 write port
//   raddr_i/data_o       mfc0 read port (combinational, 0 if unimplemented)
//   int_i                hardware interrupt lines, sampled into Cause[15:10]
//   excepttype_i         MEM exception code, 0 = none
//   current_inst_addr_i  PC of the MEM instruction
//   is_in_delayslot_i    MEM instruction sits in a delay slot
//   bad_addr_i           faulting address for code 0xf
//   count_o .. badvaddr_o  registered register values
//   timer_int_o          sticky Count==Compare interrupt
// ---------------------------------------------------------------------------
module cp0_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] data_o,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   localparam logic [31:0] PRID_VAL    = 32'h004C_0102;
   localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
   localparam logic [31:0] STATUS_RST  = 32'h1000_0000;

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        timer_int_q;
   logic [31:0] status_q;
   logic [31:0] cause_q;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;

   // Exception decode: exc_take marks the codes that enter exception level,
   // exc_code is the value placed in Cause.ExcCode.
   logic       exc_take;
   logic [4:0] exc_code;
   logic       exc_eret;

   always_comb begin
      exc_take = 1'b1;
      exc_code = 5'd0;
      case (excepttype_i)
         32'h0000_0001: exc_code = 5'h00;
         32'h0000_0008: exc_code = 5'h08;
         32'h0000_000a: exc_code = 5'h0a;
         32'h0000_000c: exc_code = 5'h0c;
         32'h0000_000d: exc_code = 5'h0d;
         32'h0000_000f: exc_code = 5'h04;
         default:       exc_take = 1'b0;
      endcase
   end

   assign exc_eret = (excepttype_i == 32'h0000_000e);

`ifdef CP0_TIMER_EN
   // Count free-runs; the match uses the pre-edge Count so the interrupt
   // appears the edge after Count reaches Compare. A Compare write clears
   // the interrupt and beats a same-edge match (later assignment wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= 32'd0;
         compare_q   <= 32'd0;
         timer_int_q <= 1'b0;
      end else begin
         count_q <= count_q + 32'd1;
         if ((compare_q != 32'd0) && (count_q == compare_q))
            timer_int_q <= 1'b1;
         if (we_i && (waddr_i == REG_COUNT))
            count_q <= data_i;
         if (we_i && (waddr_i == REG_COMPARE)) begin
            compare_q   <= data_i;
            timer_int_q <= 1'b0;
         end
      end
   end
`else
   assign count_q     = 32'd0;
   assign compare_q   = 32'd0;
   assign timer_int_q = 1'b0;
`endif

   // Write path first, exception path second: on shared fields the later
   // assignment in this block (the exception) takes effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         cause_q    <= 32'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
      end else begin
         cause_q[15:10] <= int_i;

         if (we_i) begin
            case (waddr_i)
               REG_STATUS: status_q <= data_i;
               REG_CAUSE: begin
                  cause_q[9:8]   <= data_i[9:8];
                  cause_q[23:22] <= data_i[23:22];
               end
               REG_EPC:    epc_q <= data_i;
               default:    ;
            endcase
         end

         if (exc_take) begin
            // Nested exceptions (EXL already set) keep the original EPC/BD.
            if (!status_q[1]) begin
               epc_q       <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                : current_inst_addr_i;
               cause_q[31] <= is_in_delayslot_i;
            end
            status_q[1]  <= 1'b1;
            cause_q[6:2] <= exc_code;
            if (excepttype_i == 32'h0000_000f)
               badvaddr_q <= bad_addr_i;
         end else if (exc_eret) begin
            status_q[1] <= 1'b0;
         end
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr_q;
         REG_COUNT:    data_o = count_q;
         REG_COMPARE:  data_o = compare_q;
         REG_STATUS:   data_o = status_q;
         REG_CAUSE:    data_o = cause_q;
         REG_EPC:      data_o = epc_q;
         REG_PRID:     data_o = PRID_VAL;
         REG_CONFIG:   data_o = CONFIG_VAL;
         default:      data_o = 32'd0;
      endcase
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign badvaddr_o  = badvaddr_q;
   assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// ---------------------------------------------------------------------------
// tb_cp0_reg -- self-checking bench for cp0_reg
//
// A register-level model steps once per rising edge from the sampled inputs.
// A negedge process compares every DUT output (including data_o for the
// current raddr_i) with the model. Directed vectors add literal checks.
// Follows CP0_TIMER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [5:0]  int_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] bad_addr_i;
   logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
   logic        timer_int_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   cp0_reg dut (
      .clk                 (clk),
      .rst                 (rst),
      .we_i                (we_i),
      .waddr_i             (waddr_i),
      .data_i              (data_i),
      .raddr_i             (raddr_i),
      .data_o              (data_o),
      .int_i               (int_i),
      .excepttype_i        (excepttype_i),
      .current_inst_addr_i (current_inst_addr_i),
      .is_in_delayslot_i   (is_in_delayslot_i),
      .bad_addr_i          (bad_addr_i),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .badvaddr_o          (badvaddr_o),
      .timer_int_o         (timer_int_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
`ifdef CP0_TIMER_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
   logic        m_tint;

   function automatic int exc_map(input logic [31:0] code);
      case (code)
         32'h1:   return 8'h00;
         32'h8:   return 8'h08;
         32'ha:   return 8'h0a;
         32'hc:   return 8'h0c;
         32'hd:   return 8'h0d;
         32'hf:   return 8'h04;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_bad;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h004C0102;
         5'd16:   return 32'h00008000;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] nc, ncmp, ns, nca, ne, nb;
      logic        nt;
      int          ec;
      if (rst) begin
         m_count = 0; m_compare = 0; m_status = 32'h10000000;
         m_cause = 0; m_epc = 0; m_bad = 0; m_tint = 0;
      end else begin
         nc   = m_count + 1;
         ncmp = m_compare;
         nt   = m_tint || (m_compare != 0 && m_count == m_compare);
         ns   = m_status;
         ne   = m_epc;
         nb   = m_bad;
         nca  = (m_cause & ~32'h0000FC00) | ({26'd0, int_i} << 10);
         if (we_i) begin
            if (waddr_i == 9)  nc = data_i;
            if (waddr_i == 11) begin ncmp = data_i; nt = 1'b0; end
            if (waddr_i == 12) ns = data_i;
            if (waddr_i == 13) nca = (nca & ~32'h00C00300) | (data_i & 32'h00C00300);
            if (waddr_i == 14) ne = data_i;
         end
         if (!TEN) begin nc = 0; ncmp = 0; nt = 0; end
         ec = exc_map(excepttype_i);
         if (ec >= 0) begin
            if (m_status[1] == 1'b0) begin
               ne  = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
               nca = is_in_delayslot_i ? (nca | 32'h80000000) : (nca & 32'h7FFFFFFF);
            end
            ns  = ns | 32'h2;
            nca = (nca & ~32'h0000007C) | (32'(ec) * 4);
            if (excepttype_i == 32'hf) nb = bad_addr_i;
         end else if (excepttype_i == 32'he) begin
            ns = ns & ~32'h2;
         end
         m_count = nc; m_compare = ncmp; m_tint = nt; m_status = ns;
         m_cause = nca; m_epc = ne; m_bad = nb;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_count",    count_o,     m_count);
         chk("cmp_compare",  compare_o,   m_compare);
         chk("cmp_status",   status_o,    m_status);
         chk("cmp_cause",    cause_o,     m_cause);
         chk("cmp_epc",      epc_o,       m_epc);
         chk("cmp_badvaddr", badvaddr_o,  m_bad);
         chk("cmp_timer",    {31'd0, timer_int_o}, {31'd0, m_tint});
         chk("cmp_data_o",   data_o,      m_read(raddr_i));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_i = 0; waddr_i = 0; data_i = 0;
      excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
   endtask

   task automatic do_reset();
      rst = 1; step(); step(); rst = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1; waddr_i = a; data_i = d; step(); we_i = 0;
   endtask

   task automatic raise(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bad);
      excepttype_i = code; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
      step();
      excepttype_i = 0; is_in_delayslot_i = 0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      raddr_i = a; #1;
      chk(name, data_o, exp);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1; raddr_i = 0; int_i = 0;
      idle();
      do_reset();
      chk_en = 1'b1;

      // reset image via the read port
      for (int i = 0; i < 32; i++) begin
         raddr_i = 5'(i);
         step();
      end
      rd(5'd12, 32'h10000000, "rst_status");
      rd(5'd15, 32'h004C0102, "prid");
      rd(5'd16, 32'h00008000, "config");
      rd(5'd14, 32'h0,        "rst_epc");

      // syscall then eret
      raise(32'h8, 32'h100, 1'b0, 32'h0);
      chk("sys_epc",    epc_o,    32'h100);
      chk("sys_cause",  cause_o,  32'h20);
      chk("sys_status", status_o, 32'h10000002);
      raise(32'he, 32'h0, 1'b0, 32'h0);
      chk("eret_status", status_o, 32'h10000000);
      chk("eret_epc",    epc_o,    32'h100);

      // delay-slot overflow, then nested syscall with EXL set
      raise(32'hc, 32'h204, 1'b1, 32'h0);
      chk("ds_epc",   epc_o,   32'h200);
      chk("ds_cause", cause_o, 32'h80000030);
      raise(32'h8, 32'h300, 1'b0, 32'h0);
      chk("nest_epc",   epc_o,   32'h200);
      chk("nest_cause", cause_o, 32'h80000020);

      // reset in the middle of activity: inputs ignored on reset edges
      we_i = 1; waddr_i = 14; data_i = 32'h5555; excepttype_i = 32'h8; current_inst_addr_i = 32'h80;
      do_reset();
      idle();
      chk("rst2_status", status_o, 32'h10000000);
      chk("rst2_epc",    epc_o,    32'h0);
      chk("rst2_cause",  cause_o,  32'h0);

      // same-edge mtc0 EPC and exception: exception wins
      we_i = 1; waddr_i = 14; data_i = 32'hAAAA;
      raise(32'ha, 32'h40, 1'b0, 32'h0);
      we_i = 0;
      chk("same_epc",   epc_o,   32'h40);
      chk("same_cause", cause_o, 32'h28);

      // Cause write mask with sampled interrupts
      do_reset();
      int_i = 6'h15;
      mtc0(5'd13, 32'hFFFFFFFF);
      chk("cause_wr", cause_o, 32'h00C05700);

      // address error with BadVAddr capture
      raise(32'hf, 32'h500, 1'b0, 32'hDEAD0001);
      chk("bad_vaddr", badvaddr_o, 32'hDEAD0001);
      chk("bad_cause", cause_o,    32'h00C05710);
      chk("bad_epc",   epc_o,      32'h500);

      // writes to read-only / unimplemented numbers are ignored
      mtc0(5'd8, 32'h1234);
      mtc0(5'd15, 32'h0);
      mtc0(5'd3, 32'hFFFF);
      rd(5'd8,  32'hDEAD0001, "ro_badvaddr");
      rd(5'd15, 32'h004C0102, "ro_prid");
      rd(5'd3,  32'h0,        "unimpl_3");

      // Status write together with eret: eret clears EXL of the written value
      int_i = 6'h0;
      we_i = 1; waddr_i = 12; data_i = 32'h0000FF03;
      raise(32'he, 32'h0, 1'b0, 32'h0);
      we_i = 0;
      chk("st_eret", status_o, 32'h0000FF01);

      // unrecognised nonzero code changes nothing
      raise(32'h7, 32'h900, 1'b1, 32'h0);
      chk("unk_epc", epc_o, 32'h500);

      // timer
      do_reset();
      mtc0(5'd11, 32'd10);
      mtc0(5'd9,  32'd5);
`ifdef CP0_TIMER_EN
      chk("tmr_count5", count_o, 32'd5);
      for (int i = 0; i < 5; i++) step();
      chk("tmr_before", {31'd0, timer_int_o}, 32'd0);
      step();
      chk("tmr_rise",  {31'd0, timer_int_o}, 32'd1);
      chk("tmr_count", count_o, 32'd11);
      step(); step(); step();
      chk("tmr_hold",  {31'd0, timer_int_o}, 32'd1);
      mtc0(5'd11, 32'h1000);
      chk("tmr_clear", {31'd0, timer_int_o}, 32'd0);
      // Compare write on a matching edge keeps the interrupt low
      mtc0(5'd9, 32'hFFE);
      step(); step();
      chk("tmr_cnt_match", count_o, 32'h1000);
      mtc0(5'd11, 32'h1000);
      chk("tmr_prec", {31'd0, timer_int_o}, 32'd0);
      // wrap
      mtc0(5'd9, 32'hFFFFFFFF);
      chk("wrap_max", count_o, 32'hFFFFFFFF);
      step();
      chk("wrap_zero", count_o, 32'd0);
`else
      step(); step();
      rd(5'd9,  32'd0, "notmr_count");
      rd(5'd11, 32'd0, "notmr_compare");
      chk("notmr_timer", {31'd0, timer_int_o}, 32'd0);
`endif
      step(); step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file: the state-holding counterpart of the pipeline controller's exception interface. It consumes the MEM-stage exception type and faulting PC, updates Status/Cause/EPC/BadVAddr on the exception edge, and supplies the registered EPC consumed for `eret` redirection. It also provides `mfc0`/`mtc0` access and the Count/Compare timer interrupt.

## Interface
- No parameters.
- `clk` — in, 1: single system clock, rising edge.
- `rst` — in, 1: synchronous, active-high reset (`RstEnable`).
- `we_i` — in, 1: `mtc0` write enable (from WB).
- `waddr_i` — in, 5: CP0 register number to write.
- `data_i` — in, 32: write data.
- `raddr_i` — in, 5: CP0 register number to read.
- `data_o` — out, 32: combinational read data; 0 for unimplemented numbers.
- `int_i` — in, 6: hardware interrupt lines.
- `excepttype_i` — in, 32: exception code from MEM; 0 means none.
- `current_inst_addr_i` — in, 32: PC of the MEM-stage instruction.
- `is_in_delayslot_i` — in, 1: MEM instruction is in a delay slot.
- `bad_addr_i` — in, 32: faulting address for code `0xf`.
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `badvaddr_o` — out, 32 each: registered register values.
- `timer_int_o` — out, 1: sticky timer interrupt.

## Operation
- Register map:
  - 8 BadVAddr: read-only.
  - 9 Count.
  - 11 Compare.
  - 12 Status: all bits writable.
  - 13 Cause: only bits 9:8, 22 and 23 are writable.
  - 14 EPC.
  - 15 PRId: constant `0x004C0102`.
  - 16 Config: constant `0x00008000`.
- Reset values:
  - Status = `0x10000000`.
  - Count, Compare, Cause, EPC, BadVAddr and `timer_int_o` = 0.
- Every cycle: Cause[15:10] <= `int_i`.
- Count increments by 1 each cycle and wraps modulo 2^32.
- Timer: when Compare != 0 and Count == Compare, `timer_int_o` <= 1. It holds until Compare is written.
- Write path (`we_i`=1) updates the addressed register at the edge.
  - A Count write overrides that cycle's increment.
  - A Compare write also clears `timer_int_o`. This takes precedence over a same-cycle match.
  - Writes to read-only or unimplemented numbers are ignored.
- Exception path (`excepttype_i` != 0) is evaluated after the write path in the same edge, so the exception wins on common fields.
  - Codes `0x1`, `0x8`, `0xa`, `0xc`, `0xd`, `0xf`:
    - If Status.EXL (bit 1) = 0: EPC <= `current_inst_addr_i` − 4 when `is_in_delayslot_i`, else `current_inst_addr_i`; Cause.BD (bit 31) <= `is_in_delayslot_i`.
    - If EXL = 1: EPC and BD are unchanged.
    - Always: Status.EXL <= 1, and Cause.ExcCode[6:2] is set per the mapping below.
  - ExcCode mapping: `0x1`→0x00, `0x8`→0x08, `0xa`→0x0a, `0xc`→0x0c, `0xd`→0x0d, `0xf`→0x04.
  - Code `0xf` additionally sets BadVAddr <= `bad_addr_i`.
  - Code `0xe` (`eret`): Status.EXL <= 0 only.
  - Any other nonzero code: no register change.
- No internal read/write bypass. MEM/WB forwarding of pending `mtc0` is done outside this block.

## Timing
- Reads are combinational from current state; writes and exception updates become visible the cycle after the edge.
- Exception update latency is one edge. `epc_o` used by the controller in the `eret` cycle is the value registered before that edge.
- Reset mid-operation: at the reset edge, all registers, including pending timer state, return to reset values. Inputs are ignored in that cycle.
- Count wraps from `0xFFFFFFFF` to 0 with no flag.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count/Compare and `timer_int_o` are implemented as above.
- Undefined:
  - Count and Compare are constant 0 and writes to them are ignored.
  - `count_o`, `compare_o` and `timer_int_o` are tied to 0.
  - Reads of registers 9 and 11 return 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read every number 0–31 → Status `0x10000000`, PRId `0x004C0102`, Config `0x00008000`, all others 0.
- Syscall: `excepttype_i`=`0x8`, PC=`0x100`, not delay slot → next cycle EPC=`0x100`, Cause=`0x00000020`, Status=`0x10000002`. Follow with `0xe` → Status=`0x10000000`, EPC still `0x100`.
- Delay-slot overflow: code `0xc`, PC=`0x204`, delay slot → EPC=`0x200`, Cause bit31=1, ExcCode=0x0c. A second code `0x8` at PC `0x300` with EXL=1 → EPC stays `0x200`, ExcCode=0x08.
- Timer (`CP0_TIMER_EN`): write Compare=10 and Count=5 → `timer_int_o` rises 6 cycles later and holds. A Compare write clears it next cycle.
- Same-edge `mtc0` to EPC=`0xAAAA` with code `0xa` at PC `0x40`, EXL=0 → EPC=`0x40`. Write Cause=`0xFFFFFFFF` with no exception → Cause = `0x00C00300` OR sampled `int_i`<<10.
- Code `0xf`, `bad_addr_i`=`0xDEAD0001` → BadVAddr=`0xDEAD0001`, ExcCode=0x04. Without `CP0_TIMER_EN`, reads of 9 and 11 return 0 after writes.
